// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding,
// default geometry and the counter-width helper.
package mem_arbiter_pkg;

    localparam int unsigned DEF_LATENCY = 4;
    localparam int unsigned DEF_AW      = 16;
    localparam int unsigned DEF_DW      = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    // Counter must hold LATENCY-1; one extra value keeps LATENCY=1 at 1 bit.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and memory-macro signals around the arbiter.
// slave = arbiter view, master = requesters plus memory macro.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          d_stall;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_lat_counter.sv
// Loadable down-counter that times one memory access; saturates at zero.
module lat_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data ports,
// one access in flight, alternating grants under contention.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int          AW      = DEF_AW,
    parameter int          DW      = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CW = cnt_width(LATENCY);

    arb_state_e    state_q;
    logic          last_d_q;
    logic          mem_en_q;
    logic          mem_wr_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          if_valid_q;
    logic          d_valid_q;

    logic pick_d;
    logic pick_i;
    logic busy;
    logic cnt_zero;

    // Data wins a tie unless it won the previous grant, so fetch cannot starve.
    assign pick_d = (state_q == ST_IDLE) && bus.d_req  && (!bus.if_req || !last_d_q);
    assign pick_i = (state_q == ST_IDLE) && bus.if_req && (!bus.d_req  ||  last_d_q);
    assign busy   = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);

    lat_counter #(.W(CW)) u_lat_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (pick_d | pick_i),
        .load_val_i (CW'(LATENCY - 1)),
        .dec_i      (busy),
        .zero_o     (cnt_zero)
    );

    // NOTE: every register, including the read-data holds, has a reset value so outputs are known.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_d_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_d || pick_i) begin
                        state_q    <= pick_d ? ST_BUSY_D : ST_BUSY_I;
                        last_d_q   <= pick_d;
                        mem_en_q   <= 1'b1;
                        mem_wr_q   <= pick_d & bus.d_we;
                        mem_addr_q <= pick_d ? bus.d_addr : bus.if_addr;
                        if (pick_d) begin
                            mem_wdata_q <= bus.d_wdata;
                        end
                    end
                end
                ST_BUSY_I: begin
                    if (cnt_zero) begin
                        if_rdata_q <= bus.mem_rdata;
                        if_valid_q <= 1'b1;
                        mem_en_q   <= 1'b0;
                        mem_wr_q   <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_BUSY_D: begin
                    if (cnt_zero) begin
                        // Stores complete with a valid pulse but leave the load data untouched.
                        if (!mem_wr_q) begin
                            d_rdata_q <= bus.mem_rdata;
                        end
                        d_valid_q <= 1'b1;
                        mem_en_q  <= 1'b0;
                        mem_wr_q  <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_en_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.if_stall  = bus.if_req & ~if_valid_q;
    assign bus.d_stall   = bus.d_req  & ~d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus scoreboard on the LATENCY=4
// build, and hand-written sequences for contention, mid-access reset and LATENCY=1.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int L = DEF_LATENCY;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(16), .DW(16)) bus  ();
    mem_arbiter_if #(.AW(16), .DW(16)) bus1 ();

    mem_arbiter #(.LATENCY(L), .AW(16), .DW(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    mem_arbiter #(.LATENCY(1), .AW(16), .DW(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Memory macro model: combinational read, write on the rising edge.
    logic [15:0] mem [0:65535];
    assign bus.mem_rdata  = mem[bus.mem_addr];
    assign bus1.mem_rdata = mem[bus1.mem_addr];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h5A5A;
        mem[16'h0010] = 16'hA5C3;
        mem[16'h0011] = 16'h0F0F;
        mem[16'h0020] = 16'hBEEF;
        mem[16'hFFFF] = 16'hC001;
        forever begin
            @(posedge clk);
            if (bus.mem_en && bus.mem_wr)   mem[bus.mem_addr]  = bus.mem_wdata;
            if (bus1.mem_en && bus1.mem_wr) mem[bus1.mem_addr] = bus1.mem_wdata;
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t if_q[$];
    vec_t d_q[$];
    vec_t exp_q[$];

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   grant_cyc   = 0;
    int   first_grant = -1;
    int   last_valid  = -1;
    int   en_cnt      = 0;
    int   wr_cnt      = 0;
    logic en_prev     = 1'b0;
    bit   b2b_chk     = 1'b0;
    vec_t mon_e;

    // Monitor/scoreboard then requester driver, both on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            en_cnt  = 0;
            wr_cnt  = 0;
            en_prev = 1'b0;
        end else begin
            if (bus.mem_en) begin
                if (!en_prev) begin
                    grant_cyc = cyc;
                    if (first_grant < 0) first_grant = cyc;
                    en_cnt = 0;
                    wr_cnt = 0;
                    if (b2b_chk && last_valid >= 0) check("b2b_grant", grant_cyc, last_valid + 1);
                end
                en_cnt++;
                if (bus.mem_wr) wr_cnt++;
                if (exp_q.size() > 0) begin
                    check("mem_addr", {16'h0, bus.mem_addr}, {16'h0, exp_q[0].addr});
                    check("mem_wr", {31'h0, bus.mem_wr}, {31'h0, exp_q[0].we});
                    if (exp_q[0].we) check("mem_wdata", {16'h0, bus.mem_wdata}, {16'h0, exp_q[0].wdata});
                    if (exp_q[0].is_d) check("d_stall_busy", {31'h0, bus.d_stall}, 32'd1);
                    else               check("if_stall_busy", {31'h0, bus.if_stall}, 32'd1);
                end else begin
                    check("unexpected_mem_en", {31'h0, bus.mem_en}, 32'd0);
                end
            end
            en_prev = bus.mem_en;
            if (bus.if_valid || bus.d_valid) begin
                check("valid_exclusive", {31'h0, bus.if_valid & bus.d_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {30'h0, bus.if_valid, bus.d_valid}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("valid_port", {31'h0, bus.d_valid}, {31'h0, mon_e.is_d});
                    check("latency", cyc - grant_cyc, L);
                    check("mem_en_cycles", en_cnt, L);
                    check("mem_wr_cycles", wr_cnt, mon_e.we ? L : 0);
                    if (mon_e.is_d) begin
                        check("d_rdata", {16'h0, bus.d_rdata}, {16'h0, mon_e.exp});
                        check("d_stall_valid", {31'h0, bus.d_stall}, 32'd0);
                    end else begin
                        check("if_rdata", {16'h0, bus.if_rdata}, {16'h0, mon_e.exp});
                        check("if_stall_valid", {31'h0, bus.if_stall}, 32'd0);
                    end
                end
                last_valid = cyc;
            end
        end
        // Requesters advance on their own valid pulse, before the next edge.
        if (bus.if_valid && if_q.size() > 0) if_q.delete(0);
        if (bus.d_valid && d_q.size() > 0)   d_q.delete(0);
        bus.if_req  = (if_q.size() > 0);
        bus.if_addr = (if_q.size() > 0) ? if_q[0].addr : 16'h0;
        bus.d_req   = (d_q.size() > 0);
        bus.d_we    = (d_q.size() > 0) ? d_q[0].we    : 1'b0;
        bus.d_addr  = (d_q.size() > 0) ? d_q[0].addr  : 16'h0;
        bus.d_wdata = (d_q.size() > 0) ? d_q[0].wdata : 16'h0;
    end

    task automatic push(input vec_t v);
        if (v.is_d) d_q.push_back(v);
        else        if_q.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            if (if_q.size() == 0 && d_q.size() == 0 && exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("timeout_pending", if_q.size() + d_q.size() + exp_q.size(), 0);
        if_q.delete();
        d_q.delete();
        exp_q.delete();
    endtask

    vec_t        tbl [8];
    int          rel;
    logic        seen;
    logic [15:0] l1_d_addr [2];
    logic [15:0] l1_d_exp  [2];
    logic [15:0] l1_i_addr [2];
    logic [15:0] l1_i_exp  [2];
    int          di;
    int          ii;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF};
        tbl[1] = '{1'b1, 1'b1, 16'h0100, 16'h1234, 16'hBEEF};
        tbl[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1234};
        tbl[3] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0F0F};
        tbl[4] = '{1'b1, 1'b1, 16'h0011, 16'h7777, 16'h1234};
        tbl[5] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h7777};
        tbl[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hC001};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h5A5A};

        bus1.if_req = 1'b0; bus1.if_addr = 16'h0;
        bus1.d_req  = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = 16'h0; bus1.d_wdata = 16'h0;

        // Reset with a fetch already requesting; grant must follow the release.
        rst_n = 1'b0;
        push('{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5C3});
        repeat (2) @(negedge clk);
        check("rst_mem_en",   {31'h0, bus.mem_en},   32'd0);
        check("rst_mem_wr",   {31'h0, bus.mem_wr},   32'd0);
        check("rst_mem_addr", {16'h0, bus.mem_addr}, 32'd0);
        check("rst_if_valid", {31'h0, bus.if_valid}, 32'd0);
        check("rst_d_valid",  {31'h0, bus.d_valid},  32'd0);
        check("rst_if_rdata", {16'h0, bus.if_rdata}, 32'd0);
        check("rst_d_rdata",  {16'h0, bus.d_rdata},  32'd0);
        rel   = cyc;
        rst_n = 1'b1;
        wait_done();
        check("grant_after_reset", first_grant, rel + 1);

        for (int k = 0; k < 8; k++) begin
            push(tbl[k]);
            wait_done();
        end

        // Contention with last_d=0: data, fetch, data, fetch, back to back.
        b2b_chk    = 1'b1;
        last_valid = -1;
        push('{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF});
        push('{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5C3});
        push('{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1234});
        push('{1'b0, 1'b0, 16'h0011, 16'h0000, 16'h7777});
        wait_done();
        b2b_chk = 1'b0;

        // LATENCY=1 build: alternating grants, one mem_en cycle then a valid cycle.
        l1_d_addr[0] = 16'h0020; l1_d_exp[0] = 16'hBEEF;
        l1_d_addr[1] = 16'h0100; l1_d_exp[1] = 16'h1234;
        l1_i_addr[0] = 16'h0010; l1_i_exp[0] = 16'hA5C3;
        l1_i_addr[1] = 16'h0011; l1_i_exp[1] = 16'h7777;
        di = 0;
        ii = 0;
        @(negedge clk);
        bus1.d_req  = 1'b1; bus1.d_addr  = l1_d_addr[0];
        bus1.if_req = 1'b1; bus1.if_addr = l1_i_addr[0];
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("lat1_mem_en",   {31'h0, bus1.mem_en},   32'(k % 2));
            check("lat1_d_valid",  {31'h0, bus1.d_valid},  32'((k == 2) || (k == 6)));
            check("lat1_if_valid", {31'h0, bus1.if_valid}, 32'((k == 4) || (k == 8)));
            if (bus1.d_valid && di < 2) begin
                check("lat1_d_rdata", {16'h0, bus1.d_rdata}, {16'h0, l1_d_exp[di]});
                di++;
                if (di < 2) bus1.d_addr = l1_d_addr[di];
                else        bus1.d_req  = 1'b0;
            end
            if (bus1.if_valid && ii < 2) begin
                check("lat1_if_rdata", {16'h0, bus1.if_rdata}, {16'h0, l1_i_exp[ii]});
                ii++;
                if (ii < 2) bus1.if_addr = l1_i_addr[ii];
                else        bus1.if_req  = 1'b0;
            end
        end
        bus1.d_req  = 1'b0;
        bus1.if_req = 1'b0;

        // Reset two cycles into a load: access dropped, no valid afterwards.
        push('{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF});
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                seen = 1'b1;
                break;
            end
        end
        check("midrst_started", {31'h0, seen}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mem_en",  {31'h0, bus.mem_en},   32'd0);
        check("midrst_d_valid", {31'h0, bus.d_valid},  32'd0);
        check("midrst_state",   32'(dut.state_q),      32'(ST_IDLE));
        check("midrst_d_rdata", {16'h0, bus.d_rdata},  32'd0);
        d_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus.mem_en | bus.d_valid;
        end
        check("midrst_no_valid", {31'h0, seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
